// File: rtl/bc_alu_e_mem.sv
// rtl/bc_alu_e_mem.sv - Basic Computer ALU, E flip-flop and 4K x 16 main memory slice
module bc_alu_e_mem #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic [WIDTH-1:0]      AC,
  input  logic [WIDTH-1:0]      DR,
  input  logic [2:0]            OPSEL,
  input  logic                  LD_E,
  input  logic                  CMP_E,
  input  logic                  CLR_E,
  input  logic                  MEM_WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0]      W_DATA,
  output logic [WIDTH-1:0]      RESULT,
  output logic                  CO,
  output logic                  Z,
  output logic                  N,
  output logic                  OVF,
  output logic                  E,
  output logic [WIDTH-1:0]      R_DATA
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADD  = 3'b001,
    OP_LDA  = 3'b010,
    OP_CMA  = 3'b011,
    OP_CIR  = 3'b100,
    OP_CIL  = 3'b101,
    OP_PASS = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  logic [WIDTH:0]     sum;
  logic               e_q;
  logic [WIDTH-1:0]   mem [0:DEPTH-1] = '{default: '0};

  assign sum = {1'b0, AC} + {1'b0, DR};

  always_comb begin
    RESULT = '0;
    CO     = 1'b0;
    OVF    = 1'b0;
    case (op_t'(OPSEL))
      OP_AND:  RESULT = AC & DR;
      OP_ADD: begin
        {CO, RESULT} = sum;
        OVF = (AC[WIDTH-1] == DR[WIDTH-1]) && (sum[WIDTH-1] != AC[WIDTH-1]);
      end
      OP_LDA:  RESULT = DR;
      OP_CMA:  RESULT = ~AC;
      // Rotates go through E: E shifts in, the bit shifted out becomes CO.
      OP_CIR: begin
        RESULT = {e_q, AC[WIDTH-1:1]};
        CO     = AC[0];
      end
      OP_CIL: begin
        RESULT = {AC[WIDTH-2:0], e_q};
        CO     = AC[WIDTH-1];
      end
      OP_PASS: RESULT = AC;
      OP_CLR:  RESULT = '0;
      default: RESULT = '0;
    endcase
  end

  assign Z = (RESULT == '0);
  assign N = RESULT[WIDTH-1];
  assign E = e_q;

  always_ff @(posedge clk) begin
    if (!RST_N)     e_q <= 1'b0;
    else if (CLR_E) e_q <= 1'b0;
    else if (LD_E)  e_q <= CO;
    else if (CMP_E) e_q <= ~e_q;
  end

  // Memory ignores reset so program/data survive a processor reset.
  always_ff @(posedge clk) begin
    if (MEM_WE) mem[ADDR] <= W_DATA;
  end

  assign R_DATA = mem[ADDR];

endmodule

// File: tb/tb_bc_alu_e_mem.sv
// tb/tb_bc_alu_e_mem.sv - directed self-checking bench for bc_alu_e_mem
module tb_bc_alu_e_mem;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [15:0] AC, DR, W_DATA;
  logic [2:0]  OPSEL;
  logic        LD_E, CMP_E, CLR_E, MEM_WE;
  logic [11:0] ADDR;
  logic [15:0] RESULT, R_DATA;
  logic        CO, Z, N, OVF, E;

  int errors = 0;
  int checks = 0;

  bc_alu_e_mem #(.WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk(clk), .RST_N(RST_N), .AC(AC), .DR(DR), .OPSEL(OPSEL),
    .LD_E(LD_E), .CMP_E(CMP_E), .CLR_E(CLR_E), .MEM_WE(MEM_WE),
    .ADDR(ADDR), .W_DATA(W_DATA), .RESULT(RESULT), .CO(CO), .Z(Z),
    .N(N), .OVF(OVF), .E(E), .R_DATA(R_DATA)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; AC = '0; DR = '0; OPSEL = 3'b110; LD_E = 0; CMP_E = 0; CLR_E = 0;
    MEM_WE = 0; ADDR = '0; W_DATA = '0;
    step();
    chk("reset_e", {15'd0, E}, 16'h0000);
    RST_N = 1'b1;

    MEM_WE = 1; ADDR = 12'h010; W_DATA = 16'h5A5A;
    step();
    MEM_WE = 0;
    chk("mem_010_write", R_DATA, 16'h5A5A);

    CMP_E = 1; step(); CMP_E = 0;
    chk("e_set_by_cmp", {15'd0, E}, 16'h0001);
    RST_N = 1'b0; step();
    chk("reset_clears_e", {15'd0, E}, 16'h0000);
    chk("reset_keeps_mem", R_DATA, 16'h5A5A);
    RST_N = 1'b1;

    OPSEL = 3'b001; AC = 16'h7FFF; DR = 16'h0001; #1;
    chk("add_ovf_result", RESULT, 16'h8000);
    chk("add_ovf_flags", {12'd0, CO, OVF, N, Z}, 16'b0110);
    AC = 16'hFFFF; #1;
    chk("add_wrap_result", RESULT, 16'h0000);
    chk("add_wrap_flags", {12'd0, CO, OVF, N, Z}, 16'b1001);
    LD_E = 1; step(); LD_E = 0;
    chk("ld_e_from_co", {15'd0, E}, 16'h0001);

    AC = 16'h0002; OPSEL = 3'b100; #1;
    chk("cir_result", RESULT, 16'h8001);
    chk("cir_co", {15'd0, CO}, 16'h0000);
    OPSEL = 3'b101; #1;
    chk("cil_result", RESULT, 16'h0005);
    chk("cil_co", {15'd0, CO}, 16'h0000);

    OPSEL = 3'b000; AC = 16'hF0F0; DR = 16'h3C3C; #1;
    chk("and_result", RESULT, 16'h3030);
    OPSEL = 3'b011; AC = 16'h00FF; #1;
    chk("cma_result", RESULT, 16'hFF00);
    chk("cma_flags", {12'd0, CO, OVF, N, Z}, 16'b0010);
    OPSEL = 3'b010; DR = 16'h1234; #1;
    chk("lda_result", RESULT, 16'h1234);
    OPSEL = 3'b110; #1;
    chk("pass_result", RESULT, 16'h00FF);
    OPSEL = 3'b111; #1;
    chk("clr_result", RESULT, 16'h0000);
    chk("clr_flags", {12'd0, CO, OVF, N, Z}, 16'b0001);

    OPSEL = 3'b001; AC = 16'hFFFF; DR = 16'h0001;
    CLR_E = 1; LD_E = 1; CMP_E = 1; step();
    chk("prio_clr", {15'd0, E}, 16'h0000);
    CLR_E = 0; step();
    chk("prio_ld_over_cmp", {15'd0, E}, 16'h0001);
    LD_E = 0; step();
    chk("cmp_toggle_1", {15'd0, E}, 16'h0000);
    step();
    chk("cmp_toggle_2", {15'd0, E}, 16'h0001);
    CMP_E = 0; step();
    chk("e_hold", {15'd0, E}, 16'h0001);

    MEM_WE = 1; ADDR = 12'hABC; W_DATA = 16'hBEEF; #1;
    chk("mem_old_before_edge", R_DATA, 16'h0000);
    step();
    chk("mem_abc_write", R_DATA, 16'hBEEF);
    MEM_WE = 0; W_DATA = 16'h1111; step();
    chk("mem_abc_no_write", R_DATA, 16'hBEEF);

    MEM_WE = 1; ADDR = 12'h000; W_DATA = 16'h0001; step();
    ADDR = 12'hFFF; W_DATA = 16'hFFFF; step();
    MEM_WE = 0; ADDR = 12'h000; #1;
    chk("mem_000_read", R_DATA, 16'h0001);
    ADDR = 12'hFFF; #1;
    chk("mem_fff_read", R_DATA, 16'hFFFF);
    ADDR = 12'h010; #1;
    chk("mem_010_still", R_DATA, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
